// File: rtl/mult_buf_pkg.sv
// Shared types for the multiply-to-memory block buffer: block FSM states and pipeline depth.
package mult_buf_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      DRAIN = 3'd2,
      FULL  = 3'd3,
      READ  = 3'd4
   } state_t;

   localparam int MULT_LATENCY = 3;

endpackage

// File: rtl/mult_split_pipe.sv
// Three-stage split-partial-product multiplier with a valid token shift register.
// MULT_BUF_SIGNED_EN selects two's-complement operands; otherwise operands are unsigned.
module mult_split_pipe
   import mult_buf_pkg::*;
#(
   parameter int IN_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [IN_WIDTH-1:0]   a,
   input  logic [IN_WIDTH-1:0]   b,
   output logic                  out_valid,
   output logic [2*IN_WIDTH-1:0] product
);

   localparam int H     = IN_WIDTH / 2;
   localparam int PW    = 2 * H;
   localparam int WIDTH = 2 * IN_WIDTH;

`ifdef MULT_BUF_SIGNED_EN
   localparam logic SGN = 1'b1;
`else
   localparam logic SGN = 1'b0;
`endif

   // Low halves are always unsigned; high halves carry the sign when SGN is set.
   function automatic logic signed [PW-1:0] ext_half(input logic [H-1:0] x, input logic s);
      return {{H{s & x[H-1]}}, x};
   endfunction

   function automatic logic signed [WIDTH-1:0] ext_pp(input logic signed [PW-1:0] x, input logic s);
      return {{PW{s & x[PW-1]}}, x};
   endfunction

   logic signed [PW-1:0]    w_a_lo, w_a_hi, w_b_lo, w_b_hi;
   logic signed [PW-1:0]    r_ll_p0, r_lh_p0, r_hl_p0, r_hh_p0;
   logic signed [WIDTH-1:0] w_sum;
   logic signed [WIDTH-1:0] r_sum_p1;
   logic signed [WIDTH-1:0] r_prod_p2;
   logic [MULT_LATENCY-1:0] r_vld_p;

   assign w_a_lo = ext_half(a[H-1:0], 1'b0);
   assign w_a_hi = ext_half(a[IN_WIDTH-1:H], SGN);
   assign w_b_lo = ext_half(b[H-1:0], 1'b0);
   assign w_b_hi = ext_half(b[IN_WIDTH-1:H], SGN);

   // Stage 1: four half-width partial products
   always_ff @(posedge clk) begin
      if (in_valid) begin
         r_ll_p0 <= w_a_lo * w_b_lo;
         r_lh_p0 <= w_a_lo * w_b_hi;
         r_hl_p0 <= w_a_hi * w_b_lo;
         r_hh_p0 <= w_a_hi * w_b_hi;
      end
   end

   assign w_sum = ext_pp(r_ll_p0, 1'b0)
                + (ext_pp(r_lh_p0, SGN) << H)
                + (ext_pp(r_hl_p0, SGN) << H)
                + (ext_pp(r_hh_p0, SGN) << IN_WIDTH);

   // Stage 2: full-width recombination
   always_ff @(posedge clk) begin
      if (r_vld_p[0]) r_sum_p1 <= w_sum;
   end

   // Stage 3: output register
   always_ff @(posedge clk) begin
      if (r_vld_p[1]) r_prod_p2 <= r_sum_p1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_vld_p <= '0;
      else        r_vld_p <= {r_vld_p[MULT_LATENCY-2:0], in_valid};
   end

   assign out_valid = r_vld_p[MULT_LATENCY-1];
   assign product   = r_prod_p2;

endmodule

// File: rtl/mult_block_buffer.sv
// Block buffer: accepts operand pairs, writes products to consecutive memory addresses, streams the block back.
// Operand signedness follows MULT_BUF_SIGNED_EN inside mult_split_pipe.
module mult_block_buffer
   import mult_buf_pkg::*;
#(
   parameter int  IN_WIDTH = 16,
   parameter int  LOGDEPTH = 6,
   localparam int WIDTH    = 2 * IN_WIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                EN_mult,
   input  logic [IN_WIDTH-1:0] mult_input0,
   input  logic [IN_WIDTH-1:0] mult_input1,
   output logic                RDY_mult,
   input  logic                flush,
   output logic                EN_writeMem,
   output logic [LOGDEPTH-1:0] writeMem_addr,
   output logic [WIDTH-1:0]    writeMem_val,
   input  logic                EN_blockRead,
   output logic                EN_readMem,
   output logic [LOGDEPTH-1:0] readMem_addr,
   input  logic [WIDTH-1:0]    readMem_val,
   output logic                VALID_memVal,
   output logic                LAST_memVal,
   output logic [WIDTH-1:0]    memVal_data,
   output logic [LOGDEPTH:0]   block_count
);

   localparam int DEPTH = 2 ** LOGDEPTH;
   localparam logic [LOGDEPTH:0] DEPTH_C = (LOGDEPTH + 1)'(DEPTH);

   state_t              r_state, w_state_nxt;
   logic [LOGDEPTH:0]   r_issued, w_issued_nxt;
   logic [LOGDEPTH:0]   r_written, w_written_nxt;
   logic [LOGDEPTH:0]   r_rd_ptr, w_rd_ptr_nxt;
   logic                r_alive;
   logic                r_rd_vld, r_rd_last;
   logic                w_rdy, w_accept, w_rd_en, w_rd_last;
   logic                w_pipe_vld;
   logic [WIDTH-1:0]    w_product;

   mult_split_pipe #(
      .IN_WIDTH (IN_WIDTH)
   ) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (w_accept),
      .a         (mult_input0),
      .b         (mult_input1),
      .out_valid (w_pipe_vld),
      .product   (w_product)
   );

   // r_alive keeps RDY_mult low while reset is held, rising on the first edge after release.
   assign w_rdy    = r_alive && ((r_state == IDLE) || ((r_state == FILL) && (r_issued < DEPTH_C)));
   assign w_accept = EN_mult && w_rdy;

   always_comb begin
      w_state_nxt   = r_state;
      w_issued_nxt  = r_issued;
      w_written_nxt = r_written + {{LOGDEPTH{1'b0}}, w_pipe_vld};
      w_rd_ptr_nxt  = r_rd_ptr;
      w_rd_en       = 1'b0;
      w_rd_last     = 1'b0;
      case (r_state)
         IDLE, FILL: begin
            if (w_accept) w_issued_nxt = r_issued + 1'b1;
            if ((w_issued_nxt == DEPTH_C) || (flush && (w_issued_nxt != '0)))
               w_state_nxt = DRAIN;
            else if (w_issued_nxt != '0)
               w_state_nxt = FILL;
         end
         DRAIN: begin
            if (w_written_nxt == r_issued) w_state_nxt = FULL;
         end
         FULL: begin
            if (EN_blockRead) begin
               w_state_nxt  = READ;
               w_rd_ptr_nxt = '0;
            end
         end
         READ: begin
            w_rd_en      = 1'b1;
            w_rd_ptr_nxt = r_rd_ptr + 1'b1;
            if (r_rd_ptr == (r_written - 1'b1)) begin
               w_rd_last     = 1'b1;
               w_state_nxt   = IDLE;
               w_issued_nxt  = '0;
               w_written_nxt = '0;
               w_rd_ptr_nxt  = '0;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_issued  <= '0;
         r_written <= '0;
         r_rd_ptr  <= '0;
         r_alive   <= 1'b0;
         r_rd_vld  <= 1'b0;
         r_rd_last <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_issued  <= w_issued_nxt;
         r_written <= w_written_nxt;
         r_rd_ptr  <= w_rd_ptr_nxt;
         r_alive   <= 1'b1;
         r_rd_vld  <= w_rd_en;
         r_rd_last <= w_rd_last;
      end
   end

   assign RDY_mult      = w_rdy;
   assign EN_writeMem   = w_pipe_vld;
   assign writeMem_addr = r_written[LOGDEPTH-1:0];
   assign writeMem_val  = w_pipe_vld ? w_product : '0;
   assign EN_readMem    = w_rd_en;
   assign readMem_addr  = r_rd_ptr[LOGDEPTH-1:0];
   assign VALID_memVal  = r_rd_vld;
   assign LAST_memVal   = r_rd_last;
   assign memVal_data   = r_rd_vld ? readMem_val : '0;
   assign block_count   = r_written;

endmodule

// File: tb/tb_mult_block_buffer.sv
// Directed bench for mult_block_buffer with a behavioural block memory; expectations follow MULT_BUF_SIGNED_EN.
module tb_mult_block_buffer;

   localparam int IN_WIDTH = 16;
   localparam int LOGDEPTH = 6;
   localparam int WIDTH    = 32;
   localparam int DEPTH    = 64;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                EN_mult = 1'b0;
   logic [IN_WIDTH-1:0] mult_input0 = '0;
   logic [IN_WIDTH-1:0] mult_input1 = '0;
   logic                RDY_mult;
   logic                flush = 1'b0;
   logic                EN_writeMem;
   logic [LOGDEPTH-1:0] writeMem_addr;
   logic [WIDTH-1:0]    writeMem_val;
   logic                EN_blockRead = 1'b0;
   logic                EN_readMem;
   logic [LOGDEPTH-1:0] readMem_addr;
   logic [WIDTH-1:0]    readMem_val = '0;
   logic                VALID_memVal;
   logic                LAST_memVal;
   logic [WIDTH-1:0]    memVal_data;
   logic [LOGDEPTH:0]   block_count;

   always #5 clk = ~clk;

   mult_block_buffer #(
      .IN_WIDTH (IN_WIDTH),
      .LOGDEPTH (LOGDEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .EN_mult       (EN_mult),
      .mult_input0   (mult_input0),
      .mult_input1   (mult_input1),
      .RDY_mult      (RDY_mult),
      .flush         (flush),
      .EN_writeMem   (EN_writeMem),
      .writeMem_addr (writeMem_addr),
      .writeMem_val  (writeMem_val),
      .EN_blockRead  (EN_blockRead),
      .EN_readMem    (EN_readMem),
      .readMem_addr  (readMem_addr),
      .readMem_val   (readMem_val),
      .VALID_memVal  (VALID_memVal),
      .LAST_memVal   (LAST_memVal),
      .memVal_data   (memVal_data),
      .block_count   (block_count)
   );

   typedef struct {
      logic [IN_WIDTH-1:0] a;
      logic [IN_WIDTH-1:0] b;
      logic [WIDTH-1:0]    p;
   } vec_t;

   logic [WIDTH-1:0]    mem [DEPTH];
   int                  cyc = 0;
   int                  nvec = 0;
   int                  nerr = 0;

   logic [LOGDEPTH-1:0] wa_q[$];
   logic [WIDTH-1:0]    wv_q[$];
   int                  wc_q[$];
   logic [LOGDEPTH-1:0] ra_q[$];
   int                  rc_q[$];
   logic [WIDTH-1:0]    vd_q[$];
   logic                vl_q[$];
   int                  vc_q[$];
   int                  acc_q[$];
   logic [WIDTH-1:0]    exp_q[$];

   // Synchronous-read memory model: one cycle from EN_readMem to readMem_val.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (EN_readMem) readMem_val <= mem[readMem_addr];
   end

   always @(negedge clk) begin
      if (EN_writeMem) begin
         mem[writeMem_addr] = writeMem_val;
         wa_q.push_back(writeMem_addr);
         wv_q.push_back(writeMem_val);
         wc_q.push_back(cyc);
      end
      if (EN_readMem) begin
         ra_q.push_back(readMem_addr);
         rc_q.push_back(cyc);
      end
      if (VALID_memVal) begin
         vd_q.push_back(memVal_data);
         vl_q.push_back(LAST_memVal);
         vc_q.push_back(cyc);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_q();
      wa_q.delete(); wv_q.delete(); wc_q.delete();
      ra_q.delete(); rc_q.delete(); vd_q.delete(); vl_q.delete(); vc_q.delete();
      acc_q.delete(); exp_q.delete();
   endtask

   task automatic offer(input logic [IN_WIDTH-1:0] a, input logic [IN_WIDTH-1:0] b, input logic fl);
      mult_input0 = a;
      mult_input1 = b;
      EN_mult     = 1'b1;
      flush       = fl;
      chk("rdy_at_accept", 64'(RDY_mult), 64'(1));
      acc_q.push_back(cyc);
      tick();
   endtask

   task automatic quiet();
      EN_mult      = 1'b0;
      flush        = 1'b0;
      EN_blockRead = 1'b0;
   endtask

   task automatic wait_writes(input int n, input int budget);
      int t;
      t = 0;
      while (wa_q.size() < n && t < budget) begin
         tick();
         t++;
      end
      if (wa_q.size() < n) chk("write_wait_timeout", 64'(wa_q.size()), 64'(n));
   endtask

   task automatic check_writes(input int n);
      chk("write_count", 64'(wa_q.size()), 64'(n));
      for (int i = 0; i < n && i < wa_q.size(); i++) begin
         chk($sformatf("wr_addr[%0d]", i), 64'(wa_q[i]), 64'(i));
         chk($sformatf("wr_data[%0d]", i), 64'(wv_q[i]), 64'(exp_q[i]));
         chk($sformatf("wr_latency[%0d]", i), 64'(wc_q[i]), 64'(acc_q[i] + 3));
      end
   endtask

   task automatic do_read(input int n);
      int t0;
      int t;
      ra_q.delete(); rc_q.delete(); vd_q.delete(); vl_q.delete(); vc_q.delete();
      t0 = cyc;
      EN_blockRead = 1'b1;
      tick();
      EN_blockRead = 1'b0;
      t = 0;
      while (vd_q.size() < n && t < n + 10) begin
         tick();
         t++;
      end
      tick();
      tick();
      chk("rd_issue_count", 64'(ra_q.size()), 64'(n));
      chk("rd_valid_count", 64'(vd_q.size()), 64'(n));
      for (int i = 0; i < n && i < ra_q.size(); i++) begin
         chk($sformatf("rd_addr[%0d]", i), 64'(ra_q[i]), 64'(i));
         chk($sformatf("rd_cycle[%0d]", i), 64'(rc_q[i]), 64'(t0 + 1 + i));
      end
      for (int i = 0; i < n && i < vd_q.size(); i++) begin
         chk($sformatf("rd_data[%0d]", i), 64'(vd_q[i]), 64'(exp_q[i]));
         chk($sformatf("rd_valid_cycle[%0d]", i), 64'(vc_q[i]), 64'(t0 + 2 + i));
         chk($sformatf("rd_last[%0d]", i), 64'(vl_q[i]), 64'(i == n - 1));
      end
      chk("rdy_after_read", 64'(RDY_mult), 64'(1));
      chk("count_after_read", 64'(block_count), 64'(0));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[5];
      int   k;

`ifdef MULT_BUF_SIGNED_EN
      tbl[0] = '{16'hFFFF, 16'hFFFF, 32'h0000_0001};
      tbl[1] = '{16'h8000, 16'h8000, 32'h4000_0000};
      tbl[2] = '{16'hFFFF, 16'h0002, 32'hFFFF_FFFE};
      tbl[3] = '{16'h8000, 16'h7FFF, 32'hC000_8000};
      tbl[4] = '{16'h1234, 16'h0010, 32'h0001_2340};
`else
      tbl[0] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
      tbl[1] = '{16'h8000, 16'h8000, 32'h4000_0000};
      tbl[2] = '{16'hFFFF, 16'h0002, 32'h0001_FFFE};
      tbl[3] = '{16'h8000, 16'h7FFF, 32'h3FFF_8000};
      tbl[4] = '{16'h1234, 16'h0010, 32'h0001_2340};
`endif

      // Reset state
      repeat (3) tick();
      chk("rst_rdy", 64'(RDY_mult), 64'(0));
      chk("rst_wr_en", 64'(EN_writeMem), 64'(0));
      chk("rst_wr_addr", 64'(writeMem_addr), 64'(0));
      chk("rst_wr_val", 64'(writeMem_val), 64'(0));
      chk("rst_rd_en", 64'(EN_readMem), 64'(0));
      chk("rst_rd_addr", 64'(readMem_addr), 64'(0));
      chk("rst_valid", 64'(VALID_memVal), 64'(0));
      chk("rst_last", 64'(LAST_memVal), 64'(0));
      chk("rst_data", 64'(memVal_data), 64'(0));
      chk("rst_count", 64'(block_count), 64'(0));
      rst_n = 1'b1;
      tick();
      chk("rdy_after_release", 64'(RDY_mult), 64'(1));

      // Flush with an empty block is ignored
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      chk("empty_flush_rdy", 64'(RDY_mult), 64'(1));
      chk("empty_flush_count", 64'(block_count), 64'(0));
      chk("empty_flush_writes", 64'(wa_q.size()), 64'(0));

      // Partial block from the table, flush together with the 5th accept
      clear_q();
      for (int i = 0; i < 5; i++) begin
         offer(tbl[i].a, tbl[i].b, i == 4);
         exp_q.push_back(tbl[i].p);
      end
      quiet();
      chk("partial_rdy_drain", 64'(RDY_mult), 64'(0));
      wait_writes(5, 20);
      repeat (3) tick();
      check_writes(5);
      chk("partial_count", 64'(block_count), 64'(5));
      chk("partial_rdy_full", 64'(RDY_mult), 64'(0));
      mult_input0 = 16'h1111;
      mult_input1 = 16'h2222;
      EN_mult = 1'b1;
      repeat (2) tick();
      EN_mult = 1'b0;
      repeat (5) tick();
      chk("full_ignores_mult", 64'(wa_q.size()), 64'(5));
      chk("full_count_held", 64'(block_count), 64'(5));
      do_read(5);

      // Full block of 64 back-to-back accepts
      clear_q();
      for (int i = 0; i < DEPTH; i++) begin
         offer(16'(i), 16'(i + 1), 1'b0);
         exp_q.push_back(32'(i * (i + 1)));
      end
      quiet();
      chk("rdy_after_depth", 64'(RDY_mult), 64'(0));
      k = acc_q[DEPTH-1];
      while (cyc < k + 3) tick();
      EN_blockRead = 1'b1;
      tick();
      EN_blockRead = 1'b0;
      chk("blockread_in_drain_ignored", 64'(ra_q.size()), 64'(0));
      chk("full_count", 64'(block_count), 64'(DEPTH));
      check_writes(DEPTH);
      do_read(DEPTH);

      // Gapped input, then a standalone flush
      clear_q();
      for (int i = 0; i < 6; i++) begin
         offer(16'(100 + 7 * i), 16'(3000 - 11 * i), 1'b0);
         exp_q.push_back(32'((100 + 7 * i) * (3000 - 11 * i)));
         quiet();
         tick();
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      wait_writes(6, 20);
      repeat (3) tick();
      check_writes(6);
      chk("gapped_count", 64'(block_count), 64'(6));
      do_read(6);

      // Reset with three tokens in flight
      clear_q();
      offer(16'd11, 16'd12, 1'b0);
      offer(16'd13, 16'd14, 1'b0);
      mult_input0 = 16'd15;
      mult_input1 = 16'd16;
      EN_mult = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      EN_mult = 1'b0;
      tick();
      chk("midrst_wr_en", 64'(EN_writeMem), 64'(0));
      chk("midrst_rdy", 64'(RDY_mult), 64'(0));
      chk("midrst_count", 64'(block_count), 64'(0));
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("midrst_rdy_release", 64'(RDY_mult), 64'(1));
      chk("midrst_count_release", 64'(block_count), 64'(0));
      repeat (5) tick();
      chk("midrst_no_writes", 64'(wa_q.size()), 64'(0));

      // Fresh single-entry block after reset starts at address 0
      clear_q();
      offer(16'd7, 16'd6, 1'b1);
      exp_q.push_back(32'd42);
      quiet();
      wait_writes(1, 20);
      repeat (3) tick();
      check_writes(1);
      chk("single_count", 64'(block_count), 64'(1));
      do_read(1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
